// File: rtl/gcd_pkg.sv
// Shared types and constants for the round-robin GCD arbiter and its Stein engine.
package gcd_pkg;
    localparam int OP_W     = 8;
    localparam int STEP_MAX = 24;
    localparam int NUM_REQ  = 2;

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DONE} state_t;
    typedef enum logic [1:0] {ENG_IDLE, ENG_STRIP, ENG_LOOP} eng_t;

    // Trailing-zero count of a nonzero operand; an 8-bit value has at most 7.
    function automatic logic [2:0] ctz8(input logic [OP_W-1:0] v);
        ctz8 = 3'd0;
        for (int i = OP_W - 1; i >= 0; i--)
            if (v[i]) ctz8 = i[2:0];
    endfunction
endpackage

// File: rtl/gcd_stein_seq.sv
// Sequential binary (Stein) GCD: one strip cycle for common twos, then one reduction step per cycle.
module gcd_stein_seq
    import gcd_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    output logic            finish,
    output logic [OP_W-1:0] result
);
    eng_t            phase;
    logic [OP_W-1:0] x, y;
    logic [2:0]      k;
    logic [2:0]      tz;

    assign tz     = ctz8(x | y);
    // Zero operands finish in the strip cycle with k still 0, covering gcd(x,0) and gcd(0,0).
    assign finish = (phase != ENG_IDLE) && ((x == '0) || (y == '0));
    assign result = (x | y) << k;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase <= ENG_IDLE;
            x     <= '0;
            y     <= '0;
            k     <= '0;
        end else if (start) begin
            phase <= ENG_STRIP;
            x     <= a;
            y     <= b;
            k     <= '0;
        end else if (finish) begin
            phase <= ENG_IDLE;
        end else begin
            case (phase)
                ENG_STRIP: begin
                    x     <= x >> tz;
                    y     <= y >> tz;
                    k     <= tz;
                    phase <= ENG_LOOP;
                end
                ENG_LOOP: begin
                    if (!x[0])       x <= x >> 1;
                    else if (!y[0])  y <= y >> 1;
                    else if (x >= y) x <= (x - y) >> 1;
                    else             y <= (y - x) >> 1;
                end
                default: phase <= ENG_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/gcd_arbiter.sv
// Two-requester round-robin front end sharing one gcd_stein_seq engine.
// Define GCD_ZERO_BYPASS_EN to resolve zero operands in LOAD and skip COMPUTE.
module gcd_arbiter
    import gcd_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               req0,
    input  logic [OP_W-1:0]    a0,
    input  logic [OP_W-1:0]    b0,
    input  logic               req1,
    input  logic [OP_W-1:0]    a1,
    input  logic [OP_W-1:0]    b1,
    output logic [NUM_REQ-1:0] gnt,
    output logic               done0,
    output logic               done1,
    output logic [OP_W-1:0]    result,
    output logic               busy
);
    state_t             state, state_nx;
    logic [NUM_REQ-1:0] gnt_q, gnt_nx;
    logic               ptr;
    logic [OP_W-1:0]    result_q;
    logic [OP_W-1:0]    op_a, op_b;
    logic               start;
    logic               eng_finish;
    logic [OP_W-1:0]    eng_result;

    assign op_a = gnt_q[1] ? a1 : a0;
    assign op_b = gnt_q[1] ? b1 : b0;
`ifdef GCD_ZERO_BYPASS_EN
    logic zero_op;
    assign zero_op = (op_a == '0) || (op_b == '0);
`endif

    always_comb begin
        state_nx = state;
        gnt_nx   = gnt_q;
        start    = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_nx = LOAD;
                    // ptr names the requester favoured when both contend.
                    if (req0 && req1) gnt_nx = ptr ? 2'b10 : 2'b01;
                    else              gnt_nx = req1 ? 2'b10 : 2'b01;
                end
            end
            LOAD: begin
`ifdef GCD_ZERO_BYPASS_EN
                if (zero_op) begin
                    state_nx = DONE;
                end else begin
                    start    = 1'b1;
                    state_nx = COMPUTE;
                end
`else
                start    = 1'b1;
                state_nx = COMPUTE;
`endif
            end
            COMPUTE: if (eng_finish) state_nx = DONE;
            DONE: begin
                state_nx = IDLE;
                gnt_nx   = '0;
            end
            default: begin
                state_nx = IDLE;
                gnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            gnt_q    <= '0;
            ptr      <= 1'b0;
            result_q <= '0;
        end else begin
            state <= state_nx;
            gnt_q <= gnt_nx;
            if (state == DONE) ptr <= ~ptr;
            if (state == COMPUTE && eng_finish) result_q <= eng_result;
`ifdef GCD_ZERO_BYPASS_EN
            if (state == LOAD && zero_op) result_q <= op_a | op_b;
`endif
        end
    end

    gcd_stein_seq u_eng (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (op_a),
        .b      (op_b),
        .finish (eng_finish),
        .result (eng_result)
    );

    assign gnt    = gnt_q;
    assign done0  = (state == DONE) && gnt_q[0];
    assign done1  = (state == DONE) && gnt_q[1];
    assign result = result_q;
    assign busy   = (state != IDLE);
endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed bench for gcd_arbiter: single requests, zero operands, contention, reset abort, req drop.
module tb_gcd_arbiter;
    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [7:0] a0, b0, a1, b1;
    logic [1:0] gnt;
    logic       done0, done1, busy;
    logic [7:0] result;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gcd_arbiter dut (
        .clk    (clk),
        .reset  (reset),
        .req0   (req0),
        .a0     (a0),
        .b0     (b0),
        .req1   (req1),
        .a1     (a1),
        .b1     (b1),
        .gnt    (gnt),
        .done0  (done0),
        .done1  (done1),
        .result (result),
        .busy   (busy)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Serve one request; drop_at > 0 drops req and corrupts a at that busy cycle.
    task automatic serve(input string tag, input int r, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp, input int drop_at, output int lat);
        int d_own, d_oth, gbad;
        logic [1:0] g;
        logic own;
        g = (r == 0) ? 2'b01 : 2'b10;
        if (r == 0) begin a0 = a; b0 = b; req0 = 1'b1; end
        else        begin a1 = a; b1 = b; req1 = 1'b1; end
        lat = 0; d_own = 0; d_oth = 0; gbad = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            if (busy) begin
                lat++;
                if (gnt !== g) gbad++;
            end else if (gnt !== 2'b00) gbad++;
            own = (r == 0) ? done0 : done1;
            if (cyc == drop_at) begin
                if (r == 0) begin req0 = 1'b0; a0 = a + 8'd6; end
                else        begin req1 = 1'b0; a1 = a + 8'd6; end
            end
            if (own) begin
                d_own++;
                chk({tag, "_result"}, result, exp);
                if (r == 0) req0 = 1'b0; else req1 = 1'b0;
            end
            if ((r == 0) ? done1 : done0) d_oth++;
            if (d_own > 0 && !busy) break;
        end
        chk({tag, "_done_cnt"}, d_own, 1);
        chk({tag, "_other_done"}, d_oth, 0);
        chk({tag, "_gnt_bad"}, gbad, 0);
        chk({tag, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        int lat;
        int ev, d_bad;
        int exp_who[3];
        int exp_res[3];
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        do_reset();

        chk("rst_gnt", gnt, 0);
        chk("rst_done0", done0, 0);
        chk("rst_done1", done1, 0);
        chk("rst_result", result, 0);
        chk("rst_busy", busy, 0);

        serve("r0_8_4", 0, 8'd8, 8'd4, 8'd4, 0, lat);
        chk("r0_8_4_lat_ok", (lat <= 26) ? 1 : 0, 1);
        serve("r1_67_9", 1, 8'd67, 8'd9, 8'd1, 0, lat);
        chk("r1_67_9_lat_ok", (lat <= 26) ? 1 : 0, 1);
        serve("r1_100_25", 1, 8'd100, 8'd25, 8'd25, 0, lat);
        serve("r1_25_100", 1, 8'd25, 8'd100, 8'd25, 0, lat);
        serve("r0_200_200", 0, 8'd200, 8'd200, 8'd200, 0, lat);
        serve("r0_128_64", 0, 8'd128, 8'd64, 8'd64, 0, lat);
        serve("r1_255_254", 1, 8'd255, 8'd254, 8'd1, 0, lat);
        chk("r1_255_254_lat_ok", (lat <= 26) ? 1 : 0, 1);

        serve("z_0_0", 0, 8'd0, 8'd0, 8'd0, 0, lat);
`ifdef GCD_ZERO_BYPASS_EN
        chk("z_0_0_lat", lat, 2);
`else
        chk("z_0_0_via_compute", (lat >= 3) ? 1 : 0, 1);
`endif
        serve("z_3_0", 0, 8'd3, 8'd0, 8'd3, 0, lat);
`ifdef GCD_ZERO_BYPASS_EN
        chk("z_3_0_lat", lat, 2);
`else
        chk("z_3_0_via_compute", (lat >= 3) ? 1 : 0, 1);
`endif
        serve("z_0_3", 0, 8'd0, 8'd3, 8'd3, 0, lat);
`ifdef GCD_ZERO_BYPASS_EN
        chk("z_0_3_lat", lat, 2);
`else
        chk("z_0_3_via_compute", (lat >= 3) ? 1 : 0, 1);
`endif

        // Contention from reset: 0 first, then 1 wins the next contested slot while req0 re-requests.
        do_reset();
        exp_who = '{0, 1, 0};
        exp_res = '{10, 2, 6};
        a0 = 8'd120; b0 = 8'd10; a1 = 8'd10; b1 = 8'd4;
        req0 = 1'b1; req1 = 1'b1;
        ev = 0;
        for (int cyc = 0; cyc < 150 && !(ev == 3 && !busy); cyc++) begin
            @(posedge clk); #1;
            if ((done0 || done1) && ev < 3) begin
                chk($sformatf("pair_who%0d", ev), done1 ? 1 : 0, exp_who[ev]);
                chk($sformatf("pair_res%0d", ev), result, exp_res[ev]);
                if (done0 && ev == 0) begin a0 = 8'd12; b0 = 8'd18; end
                else if (done1) req1 = 1'b0;
                else req0 = 1'b0;
                ev++;
            end
        end
        chk("pair_events", ev, 3);

        // Reset in the middle of COMPUTE abandons the operation.
        a0 = 8'd4; b0 = 8'd4; req0 = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1; req0 = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_gnt", gnt, 0);
        chk("abort_result", result, 0);
        d_bad = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done0 || done1) d_bad++;
        end
        reset = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done0 || done1 || busy) d_bad++;
        end
        chk("abort_no_done", d_bad, 0);
        serve("rereq_4_4", 0, 8'd4, 8'd4, 8'd4, 0, lat);

        // Dropping req and changing a0 after capture must not disturb the result.
        serve("drop_3_3", 0, 8'd3, 8'd3, 8'd3, 2, lat);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/gcd_arbiter.md
GCD_ARBITER -- requirements
Module: gcd_arbiter

Interface
REQ-001 The block SHALL have one clock and asynchronous, active-high reset, named as below.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0  input  1  requester 0 request; held high until done0.
REQ-005 a0, b0  input  8 each  requester 0 operands.
REQ-006 req1  input  1  requester 1 request; held high until done1.
REQ-007 a1, b1  input  8 each  requester 1 operands.
REQ-008 gnt  output  2  one-hot grant; bit i high while requester i is being served.
REQ-009 done0, done1  output  1 each  single-cycle completion pulse per requester.
REQ-010 result  output  8  GCD of the served requester's operands, valid in the done cycle, held until the next done.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 The block SHALL share one sequential Stein GCD engine between the two requesters under round-robin arbitration.
REQ-013 States: IDLE, LOAD, COMPUTE, DONE; IDLE->LOAD when any req is high; LOAD->COMPUTE after one cycle; COMPUTE->DONE when the engine signals finish; DONE->IDLE after one cycle.
REQ-014 Arbitration in IDLE: only one req high -> grant it; both high -> grant the requester not served last; priority pointer toggles in DONE.
REQ-015 Operands SHALL be captured in LOAD; later changes to a/b or req of the granted requester do not affect the computation.
REQ-016 Dropping req before done SHALL NOT abort; done still pulses and the pointer still toggles.
REQ-017 Engine: zero-check, then strip common factors of two (count k, max 7), then loop one step per cycle: shift even operand right; both odd -> larger := (larger-smaller)>>1; finish when one operand is zero; result = nonzero operand << k.
REQ-018 gcd(x,0)=gcd(0,x)=x; gcd(0,0)=0; gcd(x,x)=x.
REQ-019 All arithmetic is unsigned 8-bit; no intermediate may wrap; COMPUTE SHALL finish within 24 cycles for any 8-bit operands.
REQ-020 gnt SHALL be stable and one-hot from LOAD through DONE and zero in IDLE.
REQ-021 done_i SHALL pulse exactly once per grant, in the DONE cycle, coincident with result update.
REQ-022 A new request SHALL be granted no earlier than the cycle after DONE (back-to-back: DONE->IDLE->LOAD).

Reset
REQ-023 On reset the block SHALL enter IDLE; gnt=0, done0=done1=0, result=0, busy=0, pointer favours requester 0.
REQ-024 Reset mid-COMPUTE SHALL abandon the operation with no done pulse; the requester must re-request.

Configuration
REQ-025 With GCD_ZERO_BYPASS_EN defined, LOAD SHALL detect a zero operand and go directly to DONE with result = the other operand (latency LOAD+DONE = 2 cycles).
REQ-026 Without GCD_ZERO_BYPASS_EN, zero operands SHALL pass through COMPUTE and produce the same result per REQ-018.

Structure
REQ-027 A shared package gcd_pkg SHALL hold the state enumeration, operand width (8), step-count bound (24) and requester count (2).
REQ-028 The iterative datapath SHALL be a sub-module gcd_stein_seq (start, a, b -> finish, result); the arbiter FSM and pointer stay in gcd_arbiter.

Verification
REQ-029 req0 only, a0=8,b0=4 -> gnt=01, done0 once, result=4, done1 never.
REQ-030 req1 only, a1=67,b1=9 -> result=1 within 24 COMPUTE cycles; a1=100,b1=25 -> 25; a1=25,b1=100 -> 25.
REQ-031 a0=0,b0=0 -> result 0; a0=3,b0=0 -> 3; a0=0,b0=3 -> 3; check 2-cycle latency with GCD_ZERO_BYPASS_EN, via COMPUTE without it.
REQ-032 req0 and req1 high together after reset (a0=120,b0=10; a1=10,b1=4) -> done0 first with 10, then done1 with 2; next simultaneous pair serves requester 1 first.
REQ-033 Assert reset during COMPUTE of a0=4,b0=4 -> no done pulse, all outputs zero, IDLE; re-request -> result 4.
REQ-034 Drop req0 and change a0 mid-COMPUTE (a0=3,b0=3 captured) -> done0 still pulses with result 3.
